run_control: RTL and testbench
==============================

RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameter: DEB_CNT, default 500000, consecutive stable cycles needed to accept a step-button level change.
REQ-002 Parameter: PC_W, default 32, width of the program-counter and breakpoint compare.
REQ-003 Port: clock  input  1  single clock for all state in this block.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: run_sw  input  1  raw switch; 1 requests free-run, 0 requests halt; asynchronous to clock.
REQ-006 Port: step_n  input  1  raw push-button, active-low, bouncing; asynchronous to clock.
REQ-007 Port: bp_enable  input  1  1 enables breakpoint compare.
REQ-008 Port: bp_addr  input  PC_W  breakpoint address.
REQ-009 Port: pc  input  PC_W  current PC from the processor core.
REQ-010 Port: core_en  output  1  clock enable to the core; each cycle with core_en=1 advances the core by one cycle.
REQ-011 Port: state  output  2  current state: 00 HALT, 01 RUN, 10 STEP, 11 BREAK.
REQ-012 Port: halted  output  1  1 when state is HALT or BREAK.
REQ-013 Port: bp_hit  output  1  sticky breakpoint indicator.
REQ-014 Port: cycle_count  output  32  number of cycles with core_en=1.

Function
REQ-015 run_sw and step_n SHALL each pass through a 2-flop synchronizer before any use (run_s, step_s).
REQ-016 Debounced step level SHALL change only after step_s differs from it for DEB_CNT consecutive cycles; any intermediate match restarts the count.
REQ-017 step_press SHALL be a one-cycle pulse on the debounced 1->0 transition; release SHALL produce no event.
REQ-018 bp_match = bp_enable & bp_armed & (pc == bp_addr), full PC_W-bit compare.
REQ-019 HALT: run_s=1 -> RUN; else step_press -> STEP; else stay. Simultaneous run_s=1 and step_press: RUN, press discarded.
REQ-020 RUN: run_s=0 -> HALT; else bp_match -> BREAK; else stay. run_s=0 has priority over bp_match.
REQ-021 STEP: unconditionally -> HALT after exactly one cycle; breakpoint not evaluated; run_s and step_press ignored.
REQ-022 BREAK: run_s=0 -> HALT; else step_press -> STEP; else stay (run_s=1 alone does not resume).
REQ-023 core_en = ~reset & ((state==RUN & ~bp_match & run_s) | state==STEP); combinational from registered state, so the breaking instruction is not executed.
REQ-024 bp_armed SHALL clear on entry to BREAK and set on any cycle with core_en=1, so resume/step from a breakpoint PC executes that instruction.
REQ-025 bp_hit SHALL set on entry to BREAK and clear only on reset.
REQ-026 cycle_count SHALL increment by 1 on every cycle with core_en=1; wraps 0xFFFFFFFF -> 0 with no flag.
REQ-027 Step presses arriving in RUN or STEP SHALL be discarded, not queued.

Reset
REQ-028 While reset=1, core_en SHALL be 0 combinationally.
REQ-029 After a reset edge: state=HALT, halted=1, bp_hit=0, bp_armed=1, cycle_count=0, run_s sync flops=0, step_s sync flops=1, debounced step=1, debounce counter=0.
REQ-030 Reset asserted in any state, including mid-STEP or mid-debounce, SHALL take precedence over all transitions and discard pending events.

Verification (bench uses DEB_CNT=4)
REQ-031 Reset, then run_sw=1 -> state=RUN 3 cycles later (2 sync + 1 FSM), core_en=1, cycle_count increments each cycle; run_sw=0 -> HALT, count frozen.
REQ-032 In HALT, step_n bounces 0/1 for 3 cycles then held 0 for 10 -> exactly one STEP cycle, core_en high 1 cycle, cycle_count +1.
REQ-033 bp_enable=1, bp_addr=0x10, RUN while pc sweeps 0x0C..0x10 -> on pc=0x10 core_en=0 that cycle, state=BREAK next, bp_hit=1.
REQ-034 From BREAK at pc=0x10, one step press -> core_en 1 cycle, state STEP then HALT; run_sw low/high -> RUN, no re-break at 0x10 on first cycle.
REQ-035 Preload: run 0xFFFFFFFF enabled cycles (or force counter) -> next enabled cycle gives cycle_count=0.
REQ-036 Assert reset during STEP and during RUN with bp_hit=1 -> core_en=0 immediately, all outputs at REQ-029 values next cycle.

Source files
------------

// File: rtl/run_control.sv
// Run/halt/single-step/breakpoint controller producing the core clock enable.
// Switch and button are double-flop synchronised; the button is also debounced.
module run_control #(
    parameter int DEB_CNT = 500000,
    parameter int PC_W    = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run_sw,
    input  logic            step_n,
    input  logic            bp_enable,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    output logic            core_en,
    output logic [1:0]      state,
    output logic            halted,
    output logic            bp_hit,
    output logic [31:0]     cycle_count
);
    localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_run_meta, r_run_s;
    logic              r_step_meta, r_step_s;
    logic              r_step_deb;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_bp_armed;
    logic              r_bp_hit;
    logic [31:0]       r_cycle_count;
    logic              w_deb_done;
    logic              w_step_press;
    logic              w_bp_match;
    logic              w_enter_break;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_run_meta  <= 1'b0;
            r_run_s     <= 1'b0;
            r_step_meta <= 1'b1;
            r_step_s    <= 1'b1;
        end else begin
            r_run_meta  <= run_sw;
            r_run_s     <= r_run_meta;
            r_step_meta <= step_n;
            r_step_s    <= r_step_meta;
        end
    end

    // Any cycle where the synchronised level agrees with the debounced one restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_step_deb <= 1'b1;
            r_deb_cnt  <= '0;
        end else if (r_step_s != r_step_deb) begin
            if (r_deb_cnt == DEB_LAST) begin
                r_step_deb <= r_step_s;
                r_deb_cnt  <= '0;
            end else begin
                r_deb_cnt  <= r_deb_cnt + 1'b1;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    assign w_deb_done   = (r_step_s != r_step_deb) && (r_deb_cnt == DEB_LAST);
    assign w_step_press = w_deb_done & r_step_deb;
    assign w_bp_match   = bp_enable & r_bp_armed & (pc == bp_addr);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_HALT: begin
                if (r_run_s)           w_next = ST_RUN;
                else if (w_step_press) w_next = ST_STEP;
            end
            ST_RUN: begin
                if (!r_run_s)          w_next = ST_HALT;
                else if (w_bp_match)   w_next = ST_BREAK;
            end
            ST_STEP: begin
                w_next = ST_HALT;
            end
            ST_BREAK: begin
                if (!r_run_s)          w_next = ST_HALT;
                else if (w_step_press) w_next = ST_STEP;
            end
            default: w_next = ST_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_HALT;
        else       r_state <= w_next;
    end

    // The breaking instruction must not execute, so the match masks the enable in the same cycle.
    assign core_en = ~reset & (((r_state == ST_RUN) & ~w_bp_match & r_run_s) |
                               (r_state == ST_STEP));
    assign w_enter_break = (r_state != ST_BREAK) && (w_next == ST_BREAK);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bp_armed    <= 1'b1;
            r_bp_hit      <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            if (w_enter_break) begin
                r_bp_armed <= 1'b0;
                r_bp_hit   <= 1'b1;
            end else if (core_en) begin
                r_bp_armed <= 1'b1;
            end
            if (core_en) r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign state       = r_state;
    assign halted      = (r_state == ST_HALT) || (r_state == ST_BREAK);
    assign bp_hit      = r_bp_hit;
    assign cycle_count = r_cycle_count;
endmodule

// File: tb/tb_run_control.sv
// Bench for run_control: vector table, directed corner sequences, then random
// stimulus checked against a behavioural model of the run/step/break rules.
module tb_run_control;
    localparam int DEB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_n = 1'b1;
    logic        bp_enable = 1'b0;
    logic [31:0] bp_addr = 32'h10;
    logic [31:0] pc = 32'h0;
    logic        core_en;
    logic [1:0]  state;
    logic        halted;
    logic        bp_hit;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_fail = 0;

    run_control #(.DEB_CNT(DEB), .PC_W(32)) dut (
        .clock(clock), .reset(reset), .run_sw(run_sw), .step_n(step_n),
        .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
        .core_en(core_en), .state(state), .halted(halted),
        .bp_hit(bp_hit), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Behavioural model: 0 HALT, 1 RUN, 2 STEP, 3 BREAK.
    int          m_state = 0;
    bit          m_armed = 1'b1;
    bit          m_hit = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          m_run_hist[2] = '{1'b0, 1'b0};
    bit          m_step_hist[2] = '{1'b1, 1'b1};
    bit          m_deb = 1'b1;
    int          m_diff = 0;

    function automatic bit m_bpm();
        return bp_enable && m_armed && (pc == bp_addr);
    endfunction

    function automatic bit m_en();
        return !reset && ((m_state == 1 && m_run_hist[1] && !m_bpm()) || m_state == 2);
    endfunction

    always @(posedge clock) begin : model
        bit en, press, rs, bpm;
        int nxt;
        if (reset) begin
            m_state = 0; m_armed = 1'b1; m_hit = 1'b0; m_cnt = '0;
            m_run_hist = '{1'b0, 1'b0}; m_step_hist = '{1'b1, 1'b1};
            m_deb = 1'b1; m_diff = 0;
        end else begin
            en = m_en(); bpm = m_bpm(); rs = m_run_hist[1]; press = 1'b0;
            if (m_step_hist[1] != m_deb) begin
                m_diff++;
                if (m_diff == DEB) begin
                    press = m_deb; m_deb = m_step_hist[1]; m_diff = 0;
                end
            end else begin
                m_diff = 0;
            end
            nxt = m_state;
            case (m_state)
                0: if (rs) nxt = 1; else if (press) nxt = 2;
                1: if (!rs) nxt = 0; else if (bpm) nxt = 3;
                2: nxt = 0;
                default: if (!rs) nxt = 0; else if (press) nxt = 2;
            endcase
            if (nxt == 3 && m_state != 3) begin m_armed = 1'b0; m_hit = 1'b1; end
            if (en) begin m_armed = 1'b1; m_cnt = m_cnt + 32'd1; end
            m_state = nxt;
            m_run_hist[1] = m_run_hist[0]; m_run_hist[0] = run_sw;
            m_step_hist[1] = m_step_hist[0]; m_step_hist[0] = step_n;
        end
    end

    typedef struct {
        bit          run;
        bit          stp;
        bit          bpe;
        logic [31:0] pcv;
        logic [1:0]  st;
        bit          en;
        logic [31:0] cnt;
        bit          hit;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit s, bit b, logic [31:0] p, logic [1:0] st,
                                bit en, logic [31:0] cnt, bit hit);
        vec_t v;
        v.run = r; v.stp = s; v.bpe = b; v.pcv = p; v.st = st; v.en = en; v.cnt = cnt; v.hit = hit;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_state"}, 32'(state), 32'd0);
        chk({pfx, "_halted"}, 32'(halted), 32'd1);
        chk({pfx, "_bp_hit"}, 32'(bp_hit), 32'd0);
        chk({pfx, "_count"}, cycle_count, 32'd0);
        chk({pfx, "_core_en"}, 32'(core_en), 32'd0);
    endtask

    task automatic check_model();
        chk("rnd_state", 32'(state), 32'(m_state));
        chk("rnd_core_en", 32'(core_en), 32'(m_en()));
        chk("rnd_halted", 32'(halted), 32'((m_state == 0) || (m_state == 3)));
        chk("rnd_bp_hit", 32'(bp_hit), 32'(m_hit));
        chk("rnd_count", cycle_count, m_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1; run_sw = 1'b0; step_n = 1'b1; bp_enable = 1'b0;
        bp_addr = 32'h10; pc = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string nm);
        int k;
        k = 0;
        while (state !== s && k < 30) begin
            @(negedge clock); #1; k++;
        end
        chk(nm, 32'(state), 32'(s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_total;
        int run_hold, step_hold;

        // run, step_n, bp_en, pc | state, core_en, count, bp_hit
        vecs.push_back(mk(1,1,0,32'h00, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,32'h00, 0,0, 0,0));
        vecs.push_back(mk(1,1,0,32'h00, 1,1, 0,0));
        vecs.push_back(mk(1,1,0,32'h00, 1,1, 1,0));
        vecs.push_back(mk(0,1,0,32'h00, 1,1, 2,0));
        vecs.push_back(mk(0,1,0,32'h00, 1,1, 3,0));
        vecs.push_back(mk(0,1,0,32'h00, 1,0, 4,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0, 4,0));
        vecs.push_back(mk(0,1,0,32'h00, 0,0, 4,0));
        vecs.push_back(mk(1,1,1,32'h0C, 0,0, 4,0));
        vecs.push_back(mk(1,1,1,32'h0C, 0,0, 4,0));
        vecs.push_back(mk(1,1,1,32'h0C, 0,0, 4,0));
        vecs.push_back(mk(1,1,1,32'h0C, 1,1, 4,0));
        vecs.push_back(mk(1,1,1,32'h0D, 1,1, 5,0));
        vecs.push_back(mk(1,1,1,32'h0E, 1,1, 6,0));
        vecs.push_back(mk(1,1,1,32'h0F, 1,1, 7,0));
        vecs.push_back(mk(1,1,1,32'h10, 1,0, 8,0));
        vecs.push_back(mk(1,1,1,32'h10, 3,0, 8,1));
        vecs.push_back(mk(1,1,1,32'h10, 3,0, 8,1));
        for (int i = 0; i < 6; i++) vecs.push_back(mk(1,0,1,32'h10, 3,0, 8,1));
        vecs.push_back(mk(1,0,1,32'h10, 2,1, 8,1));
        vecs.push_back(mk(1,0,1,32'h14, 0,0, 9,1));
        vecs.push_back(mk(1,0,1,32'h14, 1,1, 9,1));
        vecs.push_back(mk(1,0,1,32'h10, 1,0,10,1));
        vecs.push_back(mk(0,0,1,32'h10, 3,0,10,1));
        vecs.push_back(mk(0,0,1,32'h10, 3,0,10,1));
        vecs.push_back(mk(1,0,1,32'h10, 3,0,10,1));
        vecs.push_back(mk(1,0,1,32'h10, 0,0,10,1));
        vecs.push_back(mk(1,0,1,32'h10, 0,0,10,1));
        vecs.push_back(mk(1,0,1,32'h10, 1,1,10,1));
        vecs.push_back(mk(1,0,1,32'h11, 1,1,11,1));
        vecs.push_back(mk(0,0,1,32'h11, 1,1,12,1));
        vecs.push_back(mk(0,0,1,32'h11, 1,1,13,1));
        vecs.push_back(mk(0,0,1,32'h11, 1,0,14,1));
        vecs.push_back(mk(0,0,1,32'h11, 0,0,14,1));

        @(negedge clock);
        do_reset();
        #1 chk_reset_vals("reset");
        @(negedge clock);
        foreach (vecs[i]) begin
            run_sw = vecs[i].run; step_n = vecs[i].stp; bp_enable = vecs[i].bpe; pc = vecs[i].pcv;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_core_en", i), 32'(core_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_count", i), cycle_count, vecs[i].cnt);
            chk($sformatf("vec%0d_bp_hit", i), 32'(bp_hit), 32'(vecs[i].hit));
            @(negedge clock);
        end

        // Bouncing button in HALT: exactly one step, nothing on release.
        do_reset();
        en_total = 0;
        for (int c = 0; c < 30; c++) begin
            step_n = (c == 1) ? 1'b1 : ((c < 13) ? 1'b0 : 1'b1);
            #1 en_total += int'(core_en);
            @(negedge clock);
        end
        chk("bounce_en_cycles", 32'(en_total), 32'd1);
        chk("bounce_count", cycle_count, 32'd1);
        chk("bounce_state", 32'(state), 32'd0);

        // Counter wrap from all-ones.
        do_reset();
        force dut.r_cycle_count = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        run_sw = 1'b1;
        @(negedge clock);
        release dut.r_cycle_count;
        repeat (2) @(negedge clock);
        #1;
        chk("wrap_state", 32'(state), 32'd1);
        chk("wrap_pre_count", cycle_count, 32'hFFFF_FFFF);
        chk("wrap_core_en", 32'(core_en), 32'd1);
        @(negedge clock);
        #1 chk("wrap_count", cycle_count, 32'd0);
        @(negedge clock);

        // Reset while in STEP.
        do_reset();
        step_n = 1'b0;
        wait_state(2'd2, "step_reached");
        reset = 1'b1; step_n = 1'b1;
        #1 chk("step_rst_core_en", 32'(core_en), 32'd0);
        @(negedge clock);
        #1 chk_reset_vals("step_rst");
        @(negedge clock);

        // Reset while running with a sticky breakpoint.
        reset = 1'b0; bp_enable = 1'b1; bp_addr = 32'h10; pc = 32'h10; run_sw = 1'b1;
        wait_state(2'd3, "brk_reached");
        pc = 32'h20; run_sw = 1'b0;
        wait_state(2'd0, "brk_to_halt");
        run_sw = 1'b1;
        wait_state(2'd1, "resume_run");
        chk("resume_bp_hit", 32'(bp_hit), 32'd1);
        chk("resume_core_en", 32'(core_en), 32'd1);
        reset = 1'b1;
        #1 chk("run_rst_core_en", 32'(core_en), 32'd0);
        @(negedge clock);
        #1 chk_reset_vals("run_rst");
        reset = 1'b0; pc = 32'h10;
        wait_state(2'd1, "rearm_run");
        chk("armed_after_reset", 32'(core_en), 32'd0);
        @(negedge clock);

        // Random stimulus against the model.
        do_reset();
        run_hold = 0; step_hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (run_hold == 0) begin
                run_sw = ($urandom_range(0, 3) != 0);
                run_hold = $urandom_range(1, 40);
            end else begin
                run_hold--;
            end
            if (step_hold == 0) begin
                step_n = ~step_n;
                step_hold = $urandom_range(1, 9);
            end else begin
                step_hold--;
            end
            bp_enable = ($urandom_range(0, 3) != 0);
            bp_addr = 32'h10 + 32'($urandom_range(0, 3));
            pc = 32'h10 + 32'($urandom_range(0, 3));
            reset = ($urandom_range(0, 299) == 0);
            #1 check_model();
            @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
